// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between two ALU requesters.
// Optional abort-on-timeout in RUN is enabled by defining MULSHARE_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] result,
  output logic               err,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             rr_ptr, rr_nxt;
  logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, start_nxt, err_nxt;
  logic [WIDTH-1:0] mul_a_nxt, mul_b_nxt;
  logic [PW-1:0]    result_nxt;

`ifdef MULSHARE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
`else
  // The timeout value only matters when the abort counter is built.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
`endif

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_nxt     = rr_ptr;
    mul_a_nxt  = mul_a;
    mul_b_nxt  = mul_b;
    result_nxt = result;
    err_nxt    = err;
    gnt0_nxt   = 1'b0;
    gnt1_nxt   = 1'b0;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    start_nxt  = 1'b0;
`ifdef MULSHARE_TIMEOUT_EN
    run_cnt_nxt = run_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_nxt = (req0 && req1) ? rr_ptr : req1;
          mul_a_nxt = owner_nxt ? a1 : a0;
          mul_b_nxt = owner_nxt ? b1 : b0;
          start_nxt = 1'b1;
          gnt0_nxt  = ~owner_nxt;
          gnt1_nxt  = owner_nxt;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        gnt0_nxt  = ~owner;
        gnt1_nxt  = owner;
        state_nxt = S_RUN;
`ifdef MULSHARE_TIMEOUT_EN
        run_cnt_nxt = '0;
`endif
      end
      S_RUN: begin
        gnt0_nxt = ~owner;
        gnt1_nxt = owner;
        if (mul_done) begin
          result_nxt = mul_product;
          err_nxt    = 1'b0;
          done0_nxt  = ~owner;
          done1_nxt  = owner;
          state_nxt  = S_RESP;
`ifdef MULSHARE_TIMEOUT_EN
        end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Final allowed RUN cycle without completion: abort with an error result.
          result_nxt = '0;
          err_nxt    = 1'b1;
          done0_nxt  = ~owner;
          done1_nxt  = owner;
          state_nxt  = S_RESP;
        end else begin
          run_cnt_nxt = run_cnt + CNT_W'(1);
`endif
        end
      end
      S_RESP: begin
        rr_nxt    = ~owner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      result    <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      mul_start <= start_nxt;
      mul_a     <= mul_a_nxt;
      mul_b     <= mul_b_nxt;
      result    <= result_nxt;
      err       <= err_nxt;
    end
  end

`ifdef MULSHARE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_cnt <= '0;
    else     run_cnt <= run_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with a behavioural multiplier of programmable latency.
module tb_mul_share_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1, err, mul_start;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic             mul_done;
  logic [PW-1:0]    mul_product;

  // Multiplier model state
  logic          model_done = 1'b0;
  logic          poke_done  = 1'b0;
  logic [PW-1:0] prod       = '0;
  int            mdelay     = 1;
  int            mcnt       = 0;
  bit            busy       = 1'b0;
  bit            start_seen;

  assign mul_done    = model_done | poke_done;
  assign mul_product = prod;

  mul_share_arbiter #(.WIDTH(WIDTH), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .err(err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // Multiplier: mul_done pulses mdelay cycles after the start cycle (mdelay 0 = never).
  initial begin
    forever begin
      @(posedge clk);
      start_seen = mul_start;
      #1;
      model_done = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (start_seen && mdelay != 0) begin
          busy = 1'b1;
          mcnt = mdelay;
          prod = PW'(mul_a) * PW'(mul_b);
        end
        if (busy) begin
          if (mcnt == 1) begin
            model_done = 1'b1;
            busy       = 1'b0;
          end else begin
            mcnt = mcnt - 1;
          end
        end
      end
    end
  end

  typedef struct {
    bit          owner;
    logic [63:0] res;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_done = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   gcnt = 0;

  task automatic push_exp(input bit owner, input logic [63:0] res, input bit er, input int lat);
    exp_t x;
    x.owner = owner;
    x.res   = res;
    x.err   = er;
    x.lat   = lat;
    sbq.push_back(x);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mul_start) begin
        n_start++;
        start_cyc = cyc;
        gcnt = 0;
      end
      if (gnt0 || gnt1) gcnt++;
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        n_vec++;
        n_err++;
        $display("FAIL exclusive: gnt=%b%b done=%b%b at cycle %0d", gnt1, gnt0, done1, done0, cyc);
      end
      if (done0 || done1) begin
        n_done++;
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL stray_done: done=%b%b result=%0d with nothing expected", done1, done0, result);
        end else begin
          e = sbq.pop_front();
          if ({done1, done0} != (e.owner ? 2'b10 : 2'b01) ||
              {gnt1, gnt0} != (e.owner ? 2'b10 : 2'b01) ||
              result != e.res || err != e.err ||
              (e.lat != 0 && ((cyc - start_cyc) != e.lat || gcnt != e.lat + 1))) begin
            n_err++;
            $display("FAIL done#%0d: got done=%b%b gnt=%b%b result=%0d err=%0d lat=%0d gcyc=%0d, expected owner=%0d result=%0d err=%0d lat=%0d gcyc=%0d",
                     n_done, done1, done0, gnt1, gnt0, result, err, cyc - start_cyc, gcnt,
                     e.owner, e.res, e.err, e.lat, e.lat + 1);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int k = 0;
    while (n_done < target && k < budget) begin
      step(1);
      k++;
    end
    n_vec++;
    if (n_done < target) begin
      n_err++;
      $display("FAIL %s: done count %0d, expected %0d within %0d cycles", nm, n_done, target, budget);
    end
  endtask

  task automatic wait_start(input int target, input int budget, input string nm);
    int k = 0;
    while (n_start < target && k < budget) begin
      step(1);
      k++;
    end
    n_vec++;
    if (n_start < target) begin
      n_err++;
      $display("FAIL %s: start count %0d, expected %0d within %0d cycles", nm, n_start, target, budget);
    end
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  function automatic logic [63:0] outs_or();
    return 64'(gnt0 | gnt1 | done0 | done1 | err | mul_start) | result | 64'(mul_a) | 64'(mul_b);
  endfunction

  int s0, d0;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step(3);
    check("reset_outputs", outs_or(), 64'd0);
    rst = 1'b0;

    // Both requesters from reset: round-robin 0,1,0
    mdelay = 3;
    a0 = 32'd2; b0 = 32'd3; a1 = 32'd4; b1 = 32'd5;
    push_exp(1'b0, 64'd6, 1'b0, 4);
    push_exp(1'b1, 64'd20, 1'b0, 4);
    push_exp(1'b0, 64'd6, 1'b0, 4);
    req0 = 1'b1; req1 = 1'b1;
    wait_start(3, 60, "rr_starts");
    req0 = 1'b0; req1 = 1'b0;
    wait_done(3, 30, "rr_done");
    step(3);

    // Single requester 0 with 33-cycle multiplier
    mdelay = 33;
    s0 = n_start;
    a0 = 32'd3; b0 = 32'd5;
    push_exp(1'b0, 64'd15, 1'b0, 34);
    req0 = 1'b1;
    wait_done(n_done + 1, 60, "single_done");
    req0 = 1'b0;
    step(3);
    check("single_start_pulses", 64'(n_start - s0), 64'd1);

    // req1 alone, then both on the cycle after done1: requester 0 wins
    mdelay = 2;
    a1 = 32'd7; b1 = 32'd6; a0 = 32'd9; b0 = 32'd9;
    push_exp(1'b1, 64'd42, 1'b0, 3);
    push_exp(1'b0, 64'd81, 1'b0, 3);
    req1 = 1'b1;
    wait_done(n_done + 1, 30, "req1_done");
    req0 = 1'b1;
    wait_start(n_start + 1, 10, "rr_after_req1");
    req0 = 1'b0; req1 = 1'b0;
    wait_done(n_done + 1, 30, "req0_after_req1");
    step(3);

    // Reset 10 cycles into RUN, req0 held through reset
    mdelay = 33;
    a0 = 32'd11; b0 = 32'd13;
    req0 = 1'b1;
    wait_start(n_start + 1, 10, "pre_reset_start");
    step(11);
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", outs_or(), 64'd0);
    sbq.delete();
    step(2);
    rst = 1'b0;
    push_exp(1'b0, 64'd143, 1'b0, 34);
    wait_done(n_done + 1, 60, "post_reset_done");
    req0 = 1'b0;
    step(3);

    // mul_done while IDLE is ignored
    d0 = n_done;
    prod = 64'd999;
    poke_done = 1'b1;
    step(1);
    poke_done = 1'b0;
    step(3);
    check("idle_mul_done_result", result, 64'd143);
    check("idle_mul_done_gnt", 64'({gnt1, gnt0, mul_start}), 64'd0);
    check("idle_mul_done_count", 64'(n_done - d0), 64'd0);

    // Multiplier never completes
    mdelay = 0;
    a0 = 32'd2; b0 = 32'd2;
    d0 = n_done;
`ifdef MULSHARE_TIMEOUT_EN
    push_exp(1'b0, 64'd0, 1'b1, 41);
    req0 = 1'b1;
    wait_done(d0 + 1, 100, "timeout_done");
    req0 = 1'b0;
    step(3);
`else
    req0 = 1'b1;
    wait_start(n_start + 1, 10, "hang_start");
    step(80);
    check("hang_gnt_held", 64'({gnt1, gnt0}), 64'd1);
    check("hang_no_done", 64'(n_done - d0), 64'd0);
    req0 = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
`endif

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
